// File: rtl/iq_upsampler.sv
// I/Q upsampler: one symbol in, FACTOR samples out (zero-stuffed).
// Define UPSAMPLER_HOLD_EN for zero-order hold instead of zeros.
module iq_upsampler #(
  parameter int DATA_W = 4,
  parameter int FACTOR = 16,
  localparam int CNT_W = (FACTOR > 1) ? $clog2(FACTOR) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] i_in,
  input  logic [DATA_W-1:0] q_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] i_up,
  output logic [DATA_W-1:0] q_up,
  output logic              sym_start,
  output logic [CNT_W-1:0]  phase,
  output logic              underrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FACTOR - 1);

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] i_up_q, i_up_d;
  logic [DATA_W-1:0] q_up_q, q_up_d;
  logic              sym_start_q, sym_start_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] i_fill, q_fill;
  logic              at_last;
  logic              accept;

`ifdef UPSAMPLER_HOLD_EN
  assign i_fill = i_up_q;
  assign q_fill = q_up_q;
`else
  assign i_fill = '0;
  assign q_fill = '0;
`endif

  assign at_last  = (phase_q == LAST);
  assign in_ready = en && ((state_q == IDLE) ||
                           (state_q == RUN && at_last));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    i_up_d      = '0;
    q_up_d      = '0;
    sym_start_d = 1'b0;
    phase_d     = '0;
    underrun_d  = 1'b0;
    if (accept) begin
      state_d     = RUN;
      out_valid_d = 1'b1;
      i_up_d      = i_in;
      q_up_d      = q_in;
      sym_start_d = 1'b1;
    end else if (state_q == RUN) begin
      if (!at_last) begin
        out_valid_d = 1'b1;
        i_up_d      = i_fill;
        q_up_d      = q_fill;
        phase_d     = phase_q + 1'b1;
      end else begin
        // Boundary with no new symbol: starved only if still enabled.
        state_d    = IDLE;
        underrun_d = en;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      i_up_q      <= '0;
      q_up_q      <= '0;
      sym_start_q <= 1'b0;
      phase_q     <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      i_up_q      <= i_up_d;
      q_up_q      <= q_up_d;
      sym_start_q <= sym_start_d;
      phase_q     <= phase_d;
      underrun_q  <= underrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign i_up      = i_up_q;
  assign q_up      = q_up_q;
  assign sym_start = sym_start_q;
  assign phase     = phase_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_iq_upsampler.sv
// Bench for iq_upsampler: FACTOR=16 and FACTOR=1 instances,
// queue scoreboard per instance plus directed flag checks.
module tb_iq_upsampler;

`ifdef UPSAMPLER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] i;
    logic [3:0] q;
    logic       ss;
    logic [3:0] ph;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       in_valid_a = 1'b0;
  logic [3:0] i_in_a = '0;
  logic [3:0] q_in_a = '0;
  logic       in_ready_a, out_valid_a, sym_start_a, underrun_a;
  logic [3:0] i_up_a, q_up_a, phase_a;

  logic       in_valid_b = 1'b0;
  logic [3:0] i_in_b = '0;
  logic [3:0] q_in_b = '0;
  logic       in_ready_b, out_valid_b, sym_start_b, underrun_b;
  logic [3:0] i_up_b, q_up_b;
  logic [0:0] phase_b;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  iq_upsampler #(.DATA_W(4), .FACTOR(16)) dut_a (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .i_in(i_in_a), .q_in(q_in_a),
    .out_valid(out_valid_a), .i_up(i_up_a), .q_up(q_up_a),
    .sym_start(sym_start_a), .phase(phase_a),
    .underrun(underrun_a)
  );

  iq_upsampler #(.DATA_W(4), .FACTOR(1)) dut_b (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .i_in(i_in_b), .q_in(q_in_b),
    .out_valid(out_valid_b), .i_up(i_up_b), .q_up(q_up_b),
    .sym_start(sym_start_b), .phase(phase_b),
    .underrun(underrun_b)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [3:0] i, input logic [3:0] q,
                        input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.i  = (k == 0 || HOLD) ? i : 4'd0;
      e.q  = (k == 0 || HOLD) ? q : 4'd0;
      e.ss = (k == 0);
      e.ph = 4'(k);
      qa.push_back(e);
    end
  endtask

  // Monitors: pop one expected sample per valid output sample.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_a) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_sample", 32'(phase_a), 32'hFFFF);
      end else begin
        e = qa.pop_front();
        chk("a_sample", {16'd0, i_up_a, q_up_a, 3'd0, sym_start_a,
                         phase_a}, {16'd0, e.i, e.q, 3'd0, e.ss, e.ph});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid_b) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_sample", 32'(i_up_b), 32'hFFFF);
      end else begin
        e = qb.pop_front();
        chk("b_sample", {16'd0, i_up_b, q_up_b, 3'd0, sym_start_b,
                         3'd0, phase_b}, {16'd0, e.i, e.q, 3'd0, e.ss,
                         e.ph});
      end
    end
  end

  initial begin
    exp_t e;
    #1;
    chk("reset_state", {27'd0, out_valid_a, sym_start_a, underrun_a,
        out_valid_b, underrun_b}, 32'd0);
    chk("reset_data", {16'd0, i_up_a, q_up_a, phase_a, 4'd0}, 32'd0);
    tick();
    reset = 1'b0;
    en = 1'b1;
    tick();
    chk("idle_ready", 32'(in_ready_a), 32'd1);

    // Single symbol then starve.
    i_in_a = 4'd7; q_in_a = 4'h8; in_valid_a = 1'b1;
    push_a(4'd7, 4'h8, 16);
    tick();
    in_valid_a = 1'b0;
    chk("t2_ready_ph0", 32'(in_ready_a), 32'd0);
    repeat (15) tick();
    chk("t2_ready_ph15", 32'(in_ready_a), 32'd1);
    tick();
    chk("t2_underrun", {30'd0, underrun_a, out_valid_a}, 32'd2);
    tick();
    chk("t2_underrun_pulse", 32'(underrun_a), 32'd0);

    // Back-to-back symbols.
    i_in_a = 4'd3; q_in_a = 4'hF; in_valid_a = 1'b1;
    push_a(4'd3, 4'hF, 16);
    tick();
    i_in_a = 4'hB; q_in_a = 4'd2;
    push_a(4'hB, 4'd2, 16);
    chk("t3_ready_ph0", 32'(in_ready_a), 32'd0);
    repeat (14) tick();
    chk("t3_ready_ph14", 32'(in_ready_a), 32'd0);
    tick();
    chk("t3_ready_ph15", 32'(in_ready_a), 32'd1);
    tick();
    in_valid_a = 1'b0;
    chk("t3_no_gap", {30'd0, out_valid_a, sym_start_a}, 32'd3);
    chk("t3_no_underrun", 32'(underrun_a), 32'd0);
    repeat (16) tick();
    chk("t3_underrun", 32'(underrun_a), 32'd1);
    tick();

    // en dropped at phase 8: symbol completes, clean stop.
    i_in_a = 4'd1; q_in_a = 4'hE; in_valid_a = 1'b1;
    push_a(4'd1, 4'hE, 16);
    tick();
    i_in_a = 4'd6; q_in_a = 4'd6;
    repeat (8) tick();
    en = 1'b0;
    repeat (7) tick();
    chk("t4_ph15", 32'(phase_a), 32'd15);
    chk("t4_ready_ph15", 32'(in_ready_a), 32'd0);
    tick();
    chk("t4_idle", {30'd0, underrun_a, out_valid_a}, 32'd0);
    chk("t4_ready_idle", 32'(in_ready_a), 32'd0);
    tick();
    chk("t4_no_underrun", 32'(underrun_a), 32'd0);
    in_valid_a = 1'b0;
    en = 1'b1;

    // Hold vs zero-stuff symbol (-3,4).
    i_in_a = 4'hD; q_in_a = 4'd4; in_valid_a = 1'b1;
    push_a(4'hD, 4'd4, 16);
    tick();
    in_valid_a = 1'b0;
    repeat (16) tick();
    tick();

    // Asynchronous reset at phase 5.
    i_in_a = 4'd2; q_in_a = 4'hD; in_valid_a = 1'b1;
    push_a(4'd2, 4'hD, 6);
    tick();
    in_valid_a = 1'b0;
    repeat (5) tick();
    chk("t1_ph5", 32'(phase_a), 32'd5);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t1_async_flags", {29'd0, out_valid_a, sym_start_a,
        underrun_a}, 32'd0);
    chk("t1_async_data", {20'd0, i_up_a, q_up_a, phase_a}, 32'd0);
    tick();
    reset = 1'b0;
    i_in_a = 4'd5; q_in_a = 4'd5; in_valid_a = 1'b1;
    push_a(4'd5, 4'd5, 16);
    tick();
    in_valid_a = 1'b0;
    chk("t1_restart_ph0", {31'd0, sym_start_a}, 32'd1);
    repeat (16) tick();
    tick();

    // FACTOR=1: pass-through with 1 clk latency.
    for (int v = 1; v <= 8; v++) begin
      i_in_b = 4'(v); q_in_b = 4'(-v); in_valid_b = 1'b1;
      e.i = 4'(v); e.q = 4'(-v); e.ss = 1'b1; e.ph = 4'd0;
      qb.push_back(e);
      tick();
      chk("t6_ready_run", 32'(in_ready_b), 32'd1);
    end
    in_valid_b = 1'b0;
    tick();
    chk("t6_underrun", {30'd0, underrun_b, out_valid_b}, 32'd2);
    tick();

    chk("queue_a_empty", 32'(qa.size()), 32'd0);
    chk("queue_b_empty", 32'(qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
